// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// LOADER_CHECKSUM_EN adds the checksum state to the encoding.
package inst_mem_loader_pkg;

   localparam int MEM_DEPTH = 256;

   // 1: first byte of a word lands in bits [31:24]
   localparam bit BYTE_ORDER_BIG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      ST_CHK   = 3'd3,
`endif
      ST_FIN   = 3'd4
   } state_t;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs accepted program bytes into a 32-bit word; flags the fourth byte.
module word_assembler
   import inst_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        last
);

   logic [1:0]  cnt_q;
   logic [31:0] shift_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 2'd0;
         shift_q <= 32'd0;
      end else if (clear) begin
         cnt_q   <= 2'd0;
      end else if (accept) begin
         cnt_q <= cnt_q + 2'd1;
         if (BYTE_ORDER_BIG)
            shift_q <= {shift_q[23:0], byte_in};
         else
            shift_q <= {byte_in, shift_q[31:8]};
      end
   end

   assign word = shift_q;
   assign last = accept && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Streams program bytes into instruction memory and holds the CPU while loading.
// Optional trailing checksum byte is enabled with LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for Start; CPU runs
// RECV  | collecting the four bytes of the current word
// WRITE | one-cycle write strobe for the assembled word
// CHK   | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// FIN   | Done pulse, then back to IDLE
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int MemDepth = MEM_DEPTH,
   parameter int AddrW    = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [AddrW-1:0] BaseAddr,
   input  logic [8:0]       Length,
   input  logic [7:0]       ByteIn,
   input  logic             ByteValid,
   output logic             ByteReady,
   output logic             WrEn,
   output logic [AddrW-1:0] WrAddr,
   output logic [31:0]      WrData,
   output logic             Busy,
   output logic             CpuRun,
   output logic             Done,
   output logic             Err
);

   state_t           state_q, state_d;
   logic [AddrW-1:0] addr_q;
   logic [8:0]       left_q;
   logic             err_q;
   logic             ready, wr, load, step, err_set;
   logic             data_accept, word_last;
   logic [AddrW:0]   end_word;
   logic             req_bad;
   logic [31:0]      word;
   logic             unused_addr_lsb;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q;
`endif

   assign unused_addr_lsb = ^BaseAddr[1:0];

   // End word index is computed one bit wider so a large base cannot wrap past the check
   assign end_word = (AddrW+1)'(BaseAddr[AddrW-1:2]) + (AddrW+1)'(Length);
   assign req_bad  = (Length == 9'd0) || (end_word > (AddrW+1)'(MemDepth));

   assign data_accept = ByteValid && (state_q == ST_RECV);

   word_assembler u_asm (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .clear   (load),
      .accept  (data_accept),
      .byte_in (ByteIn),
      .word    (word),
      .last    (word_last)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      wr      = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      err_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (req_bad) begin
                  err_set = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = ST_RECV;
               end
            end
         end
         ST_RECV: begin
            ready = 1'b1;
            if (word_last) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            wr   = 1'b1;
            step = 1'b1;
            if (left_q != 9'd1)
               state_d = ST_RECV;
            else
`ifdef LOADER_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_FIN;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         // The checksum byte needs a handshake too, so ready is also raised here
         ST_CHK: begin
            ready = 1'b1;
            if (ByteValid) begin
               if (ByteIn == csum_q) begin
                  state_d = ST_FIN;
               end else begin
                  err_set = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         addr_q <= '0;
         left_q <= 9'd0;
         err_q  <= 1'b0;
      end else begin
         err_q <= err_set;
         if (load) begin
            addr_q <= {BaseAddr[AddrW-1:2], 2'b00};
            left_q <= Length;
         end else if (step) begin
            addr_q <= addr_q + AddrW'(4);
            left_q <= left_q - 9'd1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)           csum_q <= 8'd0;
      else if (load)        csum_q <= 8'd0;
      else if (data_accept) csum_q <= csum_q + ByteIn;
   end
`endif

   assign ByteReady = ready;
   assign WrEn      = wr;
   assign WrAddr    = addr_q;
   assign WrData    = word;
   assign Busy      = (state_q != ST_IDLE);
   assign CpuRun    = !Busy;
   assign Done      = (state_q == ST_FIN);
   assign Err       = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expected writes/events,
// a negedge monitor pops and compares them. Honours LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;

   localparam int AW = 32;
   localparam logic [1:0] EV_DONE = 2'b01;
   localparam logic [1:0] EV_ERR  = 2'b10;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          Start = 1'b0;
   logic [AW-1:0] BaseAddr = '0;
   logic [8:0]    Length = 9'd0;
   logic [7:0]    ByteIn = 8'd0;
   logic          ByteValid = 1'b0;
   logic          ByteReady, WrEn, Busy, CpuRun, Done, Err;
   logic [AW-1:0] WrAddr;
   logic [31:0]   WrData;

   inst_mem_loader #(.MemDepth(256), .AddrW(AW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
      .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady), .WrEn(WrEn),
      .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .CpuRun(CpuRun), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [1:0] exp_evt[$];
   logic [7:0] stim[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         wr_count = 0;
   logic [31:0] last_wr_addr = '0;
   bit         track_run = 0;
   bit         run_bad = 0;
   wr_t        mon_e;
   logic [1:0] mon_ev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (WrEn) begin
            wr_count++;
            last_wr_addr = WrAddr;
            if (exp_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", WrAddr, WrData);
            end else begin
               mon_e = exp_wr.pop_front();
               check("wr_addr", 64'(WrAddr), 64'(mon_e.addr));
               check("wr_data", 64'(WrData), 64'(mon_e.data));
            end
         end
         if (Done || Err) begin
            if (exp_evt.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_event: got done=%0b err=%0b expected none", Done, Err);
            end else begin
               mon_ev = exp_evt.pop_front();
               check("event{err,done}", 64'({Err, Done}), 64'(mon_ev));
            end
         end
         if (track_run && CpuRun) run_bad = 1;
      end
   end

   task automatic start_load(input logic [AW-1:0] base, input logic [8:0] len);
      @(negedge Clk);
      Start = 1'b1; BaseAddr = base; Length = len;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int c;
      repeat (gap) @(negedge Clk);
      @(negedge Clk);
      ByteValid = 1'b1;
      ByteIn = b;
      c = 0;
      while (!ByteReady && c < 50) begin
         @(negedge Clk);
         c++;
      end
      if (!ByteReady) begin
         n_tests++;
         n_fail++;
         $display("FAIL byte_ready_timeout: got ready=0 expected ready=1");
         ByteValid = 1'b0;
      end else begin
         @(posedge Clk);
         #1 ByteValid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int c = 0;
      while (Busy && c < 3000) begin
         @(negedge Clk);
         c++;
      end
      check("idle_timeout", 64'(Busy), 64'd0);
      repeat (3) @(negedge Clk);
   endtask

   // Loads stim[] (len*4 bytes) at base; gap inserts an idle cycle before each byte after the first
   task automatic do_load(input logic [AW-1:0] base, input int len, input int gap, input bit bad_csum);
      logic [7:0] sum = 8'd0;
      wr_t e;
      for (int w = 0; w < len; w++) begin
         e.addr = (base & ~32'h3) + 32'(w * 4);
         e.data = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
         exp_wr.push_back(e);
      end
      for (int i = 0; i < len * 4; i++) sum = sum + stim[i];
`ifdef LOADER_CHECKSUM_EN
      exp_evt.push_back(bad_csum ? EV_ERR : EV_DONE);
`else
      exp_evt.push_back(EV_DONE);
`endif
      start_load(base, 9'(len));
      track_run = 1;
      for (int i = 0; i < len * 4; i++) send_byte(stim[i], (gap != 0 && i > 0) ? 1 : 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_csum ? sum + 8'd1 : sum, gap);
`endif
      track_run = 0;
      wait_idle();
   endtask

   task automatic reject(input string name, input logic [AW-1:0] base, input logic [8:0] len);
      bit busy_seen = 0;
      exp_evt.push_back(EV_ERR);
      start_load(base, len);
      repeat (4) begin
         if (Busy) busy_seen = 1;
         @(negedge Clk);
      end
      check(name, 64'(busy_seen), 64'd0);
   endtask

   initial begin
      int wc0;
      repeat (2) @(negedge Clk);
      check("rst_ready", 64'(ByteReady), 64'd0);
      check("rst_wren",  64'(WrEn), 64'd0);
      check("rst_addr",  64'(WrAddr), 64'd0);
      check("rst_data",  64'(WrData), 64'd0);
      check("rst_busy",  64'(Busy), 64'd0);
      check("rst_cpurun", 64'(CpuRun), 64'd1);
      check("rst_done_err", 64'({Done, Err}), 64'd0);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);

      // Two-word load, contiguous then with gaps between bytes
      stim = '{8'h8E, 8'h71, 8'h00, 8'h14, 8'h02, 8'h33, 8'h88, 8'h20};
      do_load(32'h0, 2, 0, 0);
      do_load(32'h0, 2, 1, 0);

      // Unaligned base is truncated to a word boundary
      stim = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_load(32'h107, 1, 0, 0);

      reject("busy_len0", 32'h0, 9'd0);
      reject("busy_overflow", 32'h3FC, 9'd2);
      reject("busy_len257", 32'h0, 9'd257);

      // Reset in the middle of word 0
      start_load(32'h10, 9'd1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      check("midrst_cpurun", 64'(CpuRun), 64'd1);
      check("midrst_busy",   64'(Busy), 64'd0);
      check("midrst_wren",   64'(WrEn), 64'd0);
      check("midrst_ready",  64'(ByteReady), 64'd0);
      check("midrst_addr",   64'(WrAddr), 64'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(32'h20, 1, 0, 0);

`ifdef LOADER_CHECKSUM_EN
      stim = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_load(32'h40, 1, 0, 0);
      do_load(32'h40, 1, 0, 1);
`endif

      // Full-depth load
      stim.delete();
      for (int i = 0; i < 1024; i++) stim.push_back(8'((i * 7 + 3) ^ (i >> 8)));
      wc0 = wr_count;
      run_bad = 0;
      do_load(32'h0, 256, 0, 0);
      check("full_write_count", 64'(wr_count - wc0), 64'd256);
      check("full_last_addr", 64'(last_wr_addr), 64'h3FC);
      check("full_cpurun_low", 64'(run_bad), 64'd0);

      check("pending_writes", 64'(exp_wr.size()), 64'd0);
      check("pending_events", 64'(exp_evt.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
